// File: rtl/srt_div_ctrl.sv
// Sequencing controller for the radix-8 SRT divider: handshake, digit-iteration count,
// correction cycle and special-case bypass. Optional early-out: define SRT_EARLY_OUT_EN.
module srt_div_ctrl #(
    parameter int XLEN     = 32,
    parameter int NUM_ITER = 11,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic             req_rem,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic             kill,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             load_en,
    output logic             q_capture,
    output logic             corr_en,
    output logic [1:0]       special_sel,
    output logic             op_rem,
    output logic             op_signed,
    output logic             resp_valid,
    input  logic             resp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_CORR = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NUM_ITER - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             load_reg, load_next;
    logic [1:0]       sel_reg, sel_next;
    logic             rem_reg, rem_next;
    logic             signed_reg, signed_next;

    logic accept;
    logic div_zero;
    logic sgn_ovf;
    logic early_out;

    assign req_ready = (state_reg == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign div_zero  = (divisor == '0);
    assign sgn_ovf   = req_signed && (dividend == INT_MIN) && (divisor == '1);

`ifdef SRT_EARLY_OUT_EN
    // Quotient is zero when |dividend| < |divisor|; the remainder is the dividend itself.
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    assign mag_a     = (req_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    assign mag_b     = (req_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
    assign early_out = (mag_a < mag_b);
`else
    assign early_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            load_reg   <= 1'b0;
            sel_reg    <= 2'b00;
            rem_reg    <= 1'b0;
            signed_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            load_reg   <= load_next;
            sel_reg    <= sel_next;
            rem_reg    <= rem_next;
            signed_reg <= signed_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        load_next   = 1'b0;
        sel_next    = sel_reg;
        rem_next    = rem_reg;
        signed_next = signed_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    rem_next    = req_rem;
                    signed_next = req_signed;
                    if (div_zero) begin
                        sel_next   = 2'b01;
                        state_next = ST_DONE;
                    end else if (sgn_ovf) begin
                        sel_next   = 2'b10;
                        state_next = ST_DONE;
                    end else begin
                        sel_next   = 2'b00;
                        load_next  = 1'b1;
                        if (early_out) begin
                            state_next = ST_CORR;
                        end else begin
                            state_next = ST_ITER;
                            cnt_next   = CNT_INIT;
                        end
                    end
                end
            end
            ST_ITER: begin
                if (cnt_reg == '0) begin
                    state_next = ST_CORR;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_CORR: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                sel_next   = 2'b00;
            end
        endcase

        // Flush wins over everything, including a same-cycle accept or response handshake.
        if (kill) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            load_next   = 1'b0;
            sel_next    = 2'b00;
            rem_next    = rem_reg;
            signed_next = signed_reg;
        end
    end

    assign phase       = state_reg;
    assign iter_cnt    = cnt_reg;
    assign load_en     = load_reg;
    assign q_capture   = (state_reg == ST_CORR);
    assign corr_en     = (state_reg == ST_CORR);
    assign special_sel = sel_reg;
    assign op_rem      = rem_reg;
    assign op_signed   = signed_reg;
    assign resp_valid  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Scoreboard bench for srt_div_ctrl: driver pushes model expectations, monitor checks responses.
module tb_srt_div_ctrl;

    localparam int XLEN     = 32;
    localparam int NUM_ITER = 11;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic             req_rem;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic             kill;
    logic [1:0]       phase;
    logic [CNT_W-1:0] iter_cnt;
    logic             load_en;
    logic             q_capture;
    logic             corr_en;
    logic [1:0]       special_sel;
    logic             op_rem;
    logic             op_signed;
    logic             resp_valid;
    logic             resp_ready;

    srt_div_ctrl #(.XLEN(XLEN), .NUM_ITER(NUM_ITER), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_signed(req_signed), .req_rem(req_rem), .dividend(dividend), .divisor(divisor),
        .kill(kill), .phase(phase), .iter_cnt(iter_cnt), .load_en(load_en),
        .q_capture(q_capture), .corr_en(corr_en), .special_sel(special_sel),
        .op_rem(op_rem), .op_signed(op_signed), .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        int         lat;
        int         iters;
        int         loads;
        int         caps;
        logic       rem;
        logic       sgn;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   iter_seen = 0;
    int   load_seen = 0;
    int   cap_seen = 0;
    bit   pending_acc = 0;
    bit   resp_seen = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: RISC-V special cases first, then the quotient-is-zero shortcut, else full loop.
    function automatic exp_t model(input bit sgn, input bit rem, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint ma, mb;
        e.rem = rem;
        e.sgn = sgn;
        ma = sgn ? (($signed(a) < 0) ? -longint'($signed(a)) : longint'($signed(a))) : longint'(a);
        mb = sgn ? (($signed(b) < 0) ? -longint'($signed(b)) : longint'($signed(b))) : longint'(b);
        if (b == 0) begin
            e.sel = 2'b01; e.lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.sel = 2'b10; e.lat = 1;
        end else begin
            e.sel = 2'b00;
`ifdef SRT_EARLY_OUT_EN
            e.lat = (ma < mb) ? 2 : NUM_ITER + 2;
`else
            e.lat = NUM_ITER + 2;
`endif
        end
        e.iters = (e.lat == NUM_ITER + 2) ? NUM_ITER : 0;
        e.loads = (e.sel == 2'b00) ? 1 : 0;
        e.caps  = (e.sel == 2'b00) ? 1 : 0;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (pending_acc) begin
            acc_cyc     = cyc;
            iter_seen   = 0;
            load_seen   = 0;
            cap_seen    = 0;
            pending_acc = 0;
        end
    end

    // Monitor: samples on the falling edge, pops one expectation per response.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending_acc = 0;
            resp_seen   = 0;
        end else begin
            if (req_valid && req_ready && !kill) pending_acc = 1;
            if (phase == 2'b01) iter_seen++;
            if (load_en) load_seen++;
            if (q_capture && corr_en) cap_seen++;
            if (resp_valid && !resp_seen) begin
                resp_seen = 1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got response, expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("latency", cyc - acc_cyc + 1, e.lat);
                    check("special_sel", special_sel, e.sel);
                    check("op_rem", op_rem, e.rem);
                    check("op_signed", op_signed, e.sgn);
                    check("iter_cycles", iter_seen, e.iters);
                    check("load_pulses", load_seen, e.loads);
                    check("q_capture", cap_seen, e.caps);
                    $display("resp: sel=%0d lat=%0d iters=%0d rem=%0d sgn=%0d", special_sel,
                             cyc - acc_cyc + 1, iter_seen, op_rem, op_signed);
                end
            end else if (!resp_valid) begin
                resp_seen = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit sgn, input bit rem, input logic [31:0] a, input logic [31:0] b);
        check("req_ready_before", req_ready, 1);
        req_valid = 1; req_signed = sgn; req_rem = rem; dividend = a; divisor = b;
        exp_q.push_back(model(sgn, rem, a, b));
        step();
        req_valid = 0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!resp_valid && n < 40) begin
            step();
            n++;
        end
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got resp_valid=0, expected 1 within 40 cycles");
        end
    endtask

    task automatic finish_txn(input int hold);
        logic [1:0] sel0;
        sel0 = special_sel;
        for (int i = 0; i < hold; i++) begin
            step();
            check("resp_held", resp_valid, 1);
            check("sel_held", special_sel, sel0);
        end
        resp_ready = 1;
        step();
        resp_ready = 0;
        check("idle_phase", phase, 0);
        check("idle_ready", req_ready, 1);
    endtask

    task automatic txn(input bit sgn, input bit rem, input logic [31:0] a, input logic [31:0] b, input int hold);
        $display("req: sgn=%0d rem=%0d a=%h b=%h hold=%0d", sgn, rem, a, b, hold);
        issue(sgn, rem, a, b);
        wait_resp();
        finish_txn(hold);
    endtask

    initial begin
        rst_n = 0; req_valid = 0; req_signed = 0; req_rem = 0;
        dividend = '0; divisor = '0; kill = 0; resp_ready = 0;
        repeat (2) step();
        check("rst_phase", phase, 0);
        check("rst_iter_cnt", iter_cnt, 0);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_load_en", load_en, 0);
        check("rst_q_capture", q_capture, 0);
        check("rst_special_sel", special_sel, 0);
        check("rst_op_rem", op_rem, 0);
        rst_n = 1;
        step();

        // Unsigned 100/7 with direct checks of the first ITER cycle and a 3-cycle stall
        $display("req: unsigned 100/7");
        issue(0, 0, 100, 7);
        check("t1_phase_iter", phase, 1);
        check("t1_load_en", load_en, 1);
        check("t1_iter_cnt", iter_cnt, NUM_ITER - 1);
        wait_resp();
        finish_txn(3);

        // Divide by zero and signed overflow bypass the loop
        txn(1, 0, 32'd55, 32'd0, 0);
        txn(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        txn(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        txn(1, 1, 32'h8000_0000, 32'd0, 0);

        // Kill mid-iteration, then an immediate fresh request
        $display("req: kill at iter_cnt=5");
        issue(1, 0, 32'd12345, 32'd17);
        begin
            int n = 0;
            while (!(phase == 2'b01 && iter_cnt == 5) && n < 30) begin step(); n++; end
            check("kill_reach_cnt5", iter_cnt, 5);
        end
        kill = 1;
        step();
        kill = 0;
        void'(exp_q.pop_back());
        check("kill_phase", phase, 0);
        check("kill_ready", req_ready, 1);
        check("kill_resp_valid", resp_valid, 0);
        check("kill_sel", special_sel, 0);
        txn(0, 0, 32'd999, 32'd3, 0);

        // Kill coinciding with an accept drops the request
        $display("req: kill with accept");
        req_valid = 1; dividend = 32'd8; divisor = 32'd0; kill = 1;
        step();
        req_valid = 0; kill = 0;
        check("killacc_phase", phase, 0);
        check("killacc_sel", special_sel, 0);
        repeat (2) step();
        check("killacc_no_resp", resp_valid, 0);

        // Kill beats resp_ready in DONE
        issue(0, 1, 32'd1, 32'd0);
        wait_resp();
        kill = 1; resp_ready = 1;
        step();
        kill = 0; resp_ready = 0;
        check("kill_done_phase", phase, 0);
        check("kill_done_sel", special_sel, 0);

        // Reset while a response is pending
        $display("req: reset during DONE");
        issue(1, 1, 32'd77, 32'd5);
        wait_resp();
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        check("rstdone_resp_valid", resp_valid, 0);
        check("rstdone_phase", phase, 0);
        check("rstdone_iter_cnt", iter_cnt, 0);
        check("rstdone_op_rem", op_rem, 0);
        txn(0, 0, 32'd50, 32'd7, 0);
        txn(1, 1, 32'hFFFF_FF00, 32'd9, 0);

        // Quotient-zero operands (early-out candidate)
        txn(0, 0, 32'd3, 32'd1000, 0);
        txn(1, 0, 32'hFFFF_FFFD, 32'd1000, 0);

        // Randomised mix
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            int kind;
            kind = $urandom_range(0, 5);
            a = $urandom();
            b = $urandom();
            case (kind)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = $urandom_range(0, 50); b = $urandom_range(51, 5000); end
                4: b = $urandom_range(1, 7);
                5: begin a = 32'h8000_0000; b = 32'd1; end
                default: ;
            endcase
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
        end

        repeat (2) step();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
